// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: func3 codes, FSM state,
// burst length and the byte-enable / load-extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned WIDE_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Legal width codes: loads accept B/H/W/BU/HU, stores only B/H/W.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment of a scalar access for the given width code.
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3)
            F3_H, F3_HU: ok = !off[0];
            F3_W:        ok = (off == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by a scalar store.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low bits across the word so any enabled lane sees the right byte.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] d;
        case (f3)
            F3_B:    d = {4{wdata[7:0]}};
            F3_H:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed byte/half from a RAM word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Ports: clk; en (access strobe); wen (byte enables, 0 = read);
// addr (word address); wdata; rdata (read data, 1-cycle latency, held
// until the next read).
module dmem_bank #(
    parameter  int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes; a read happens only on accesses with no lane enabled.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (wen == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage access port.
// Scalar RV32I loads/stores complete in one cycle; 128-bit matrix accesses
// run as a 4-beat burst over the 32-bit bank.
// Ports: clk, rst (sync, active high); req_valid/req_ready handshake with
// req_write, req_wide, req_func3, req_addr, req_wdata, req_wmatrix;
// rsp_valid pulse with rsp_rdata, rsp_rmatrix, rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_wide,
    input  logic [2:0]   req_func3,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic [127:0] req_wmatrix,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic [127:0] rsp_rmatrix,
    output logic         rsp_err
);

    state_t         state;
    logic [1:0]     beat_r;
    logic [AW-1:0]  base_r;
    logic [127:0]   wmat_r;
    logic           wr_r;
    logic           wide_ld_r;
    logic           ld_pend_r;
    logic [2:0]     f3_r;
    logic [1:0]     off_r;
    logic           valid_r;
    logic           err_r;
    logic [31:0]    rdata_r;
    logic [127:0]   rmatrix_r;

    logic           accept;
    logic           err_c;
    logic [1:0]     lane;
    logic [31:0]    rdata_c;
    logic [127:0]   rmatrix_c;

    logic           ram_en;
    logic [3:0]     ram_wen;
    logic [AW-1:0]  ram_addr;
    logic [31:0]    ram_wdata;
    logic [31:0]    ram_rdata;

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
        .clk   (clk),
        .en    (ram_en),
        .wen   (ram_wen),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign lane      = beat_r - 2'd1;

    // Request checks: range, then wide alignment or scalar width/alignment.
    always_comb begin
        err_c = (req_addr[31:AW+2] != '0);
        if (req_wide) begin
            err_c = err_c || (req_addr[3:0] != 4'd0);
        end else begin
            err_c = err_c || !f3_legal(req_write, req_func3)
                          || !f3_aligned(req_func3, req_addr[1:0]);
        end
    end

    // Bank port: beat 0 / scalar access from the live request, beats 1..3 from the burst registers.
    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 4'b0000;
        ram_addr  = req_addr[AW+1:2];
        ram_wdata = store_data(req_func3, req_wdata);
        if (accept && !err_c) begin
            ram_en = 1'b1;
            if (req_wide) begin
                ram_wdata = req_wmatrix[31:0];
                ram_wen   = req_write ? 4'b1111 : 4'b0000;
            end else begin
                ram_wen   = req_write ? store_be(req_func3, req_addr[1:0]) : 4'b0000;
            end
        end else if (state == BURST && !rst) begin
            ram_en    = 1'b1;
            ram_addr  = base_r + AW'(beat_r);
            ram_wdata = wmat_r[{beat_r, 5'b0} +: 32];
            ram_wen   = wr_r ? 4'b1111 : 4'b0000;
        end
    end

    // Read data arrives from the bank in the response cycle, so the response
    // lanes are formatted combinationally and then latched to hold.
    always_comb begin
        rdata_c   = ld_pend_r ? load_ext(ram_rdata, f3_r, off_r) : rdata_r;
        rmatrix_c = (state == DONE && wide_ld_r) ? {ram_rdata, rmatrix_r[95:0]} : rmatrix_r;
    end

    assign rsp_valid   = valid_r && !rst;
    assign rsp_err     = err_r && !rst;
    assign rsp_rdata   = rst ? 32'd0 : rdata_c;
    assign rsp_rmatrix = rst ? 128'd0 : rmatrix_c;

    // Control FSM and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_r    <= 2'd0;
            base_r    <= '0;
            wmat_r    <= '0;
            wr_r      <= 1'b0;
            wide_ld_r <= 1'b0;
            ld_pend_r <= 1'b0;
            f3_r      <= 3'd0;
            off_r     <= 2'd0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= 32'd0;
            rmatrix_r <= 128'd0;
        end else begin
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            ld_pend_r <= 1'b0;
            rdata_r   <= rdata_c;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (err_c) begin
                            valid_r   <= 1'b1;
                            err_r     <= 1'b1;
                            rdata_r   <= 32'd0;
                            rmatrix_r <= 128'd0;
                        end else if (req_wide) begin
                            state     <= BURST;
                            beat_r    <= 2'd1;
                            base_r    <= req_addr[AW+1:2];
                            wmat_r    <= req_wmatrix;
                            wr_r      <= req_write;
                            wide_ld_r <= !req_write;
                        end else begin
                            valid_r   <= 1'b1;
                            ld_pend_r <= !req_write;
                            f3_r      <= req_func3;
                            off_r     <= req_addr[1:0];
                            if (req_write) begin
                                rdata_r <= 32'd0;
                            end
                        end
                    end
                end
                BURST: begin
                    // The bank output now holds the previous beat's word.
                    if (wide_ld_r) begin
                        rmatrix_r[{lane, 5'b0} +: 32] <= ram_rdata;
                    end
                    if (beat_r == 2'(WIDE_BEATS - 1)) begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                    end else begin
                        beat_r <= beat_r + 2'd1;
                    end
                end
                DONE: begin
                    if (wide_ld_r) begin
                        rmatrix_r[127:96] <= ram_rdata;
                    end
                    wide_ld_r <= 1'b0;
                    beat_r    <= 2'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-built timing
// sequences and randomized traffic against a byte-array memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic         req_wide;
    logic [2:0]   req_func3;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [127:0] req_wmatrix;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic [127:0] rsp_rmatrix;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [0:16383];

    dmem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_wide    (req_wide),
        .req_func3   (req_func3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmatrix (req_wmatrix),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_rmatrix (rsp_rmatrix),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic         wide;
        logic [2:0]   f3;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] wmat;
        logic         e;
        int           lat;
        logic         chk_rd;
        logic [31:0]  rd;
        logic         chk_rm;
        logic [127:0] rm;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic wide, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [127:0] wmat, input logic e, input int lat,
                                input logic chk_rd, input logic [31:0] rd,
                                input logic chk_rm, input logic [127:0] rm);
        vec_t v;
        v.wr = wr; v.wide = wide; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.wmat = wmat;
        v.e = e; v.lat = lat; v.chk_rd = chk_rd; v.rd = rd; v.chk_rm = chk_rm; v.rm = rm;
        return v;
    endfunction

    // Reference: byte-addressed memory, expectations from the access rules.
    task automatic model_exec(input logic wr, input logic wide, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [127:0] wmat, output logic e, output int lat,
                              output logic [31:0] rd, output logic [127:0] rm);
        int size;
        logic legal;
        logic [31:0] v;
        e = 1'b0; lat = 1; rd = 32'd0; rm = 128'd0;
        if (wide) size = 16;
        else begin
            case (f3)
                3'd0, 3'd4: size = 1;
                3'd1, 3'd5: size = 2;
                3'd2:       size = 4;
                default:    size = 0;
            endcase
        end
        if (wide) legal = 1'b1;
        else if (wr) legal = (f3 <= 3'd2);
        else legal = (size != 0);
        if (!legal) e = 1'b1;
        else if (addr >= 32'd16384 || (addr % size) != 0) e = 1'b1;
        if (e) return;
        if (wide) begin
            lat = 4;
            for (int i = 0; i < 16; i++) begin
                if (wr) mem_m[addr + i] = wmat[8*i +: 8];
                else    rm[8*i +: 8] = mem_m[addr + i];
            end
        end else if (wr) begin
            for (int i = 0; i < size; i++) mem_m[addr + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[addr + i];
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            rd = v;
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input logic wr, input logic wide, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [127:0] wmat, output int lat, output logic e,
                         output logic [31:0] rd, output logic [127:0] rm);
        int w;
        logic ok;
        lat = 0; e = 1'b0; rd = 32'd0; rm = 128'd0;
        req_valid = 1'b1; req_write = wr; req_wide = wide; req_func3 = f3;
        req_addr = addr; req_wdata = wdata; req_wmatrix = wmat;
        w = 0; ok = 1'b0;
        while (!ok && w <= 20) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else w++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_ready_timeout: got req_ready=0 for %0d cycles expected 1", w);
            req_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 1'b0;
        while (!ok && lat <= 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_rsp_timeout: got no rsp_valid expected a response");
            lat = 0;
        end else begin
            e = rsp_err; rd = rsp_rdata; rm = rsp_rmatrix;
        end
        @(posedge clk); #1;
    endtask

    localparam logic [127:0] MAT = 128'h44444444_33333333_22222222_11111111;

    initial begin
        int lat;
        logic e;
        logic [31:0] rd;
        logic [127:0] rm;
        int elat;
        logic ee;
        logic [31:0] erd;
        logic [127:0] erm;
        logic [31:0] exp_b2b [8];
        logic seen;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
        req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_wmatrix = 128'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   128'(req_ready),   128'(0));
        chk("rst_valid",   128'(rsp_valid),   128'(0));
        chk("rst_err",     128'(rsp_err),     128'(0));
        chk("rst_rdata",   128'(rsp_rdata),   128'(0));
        chk("rst_rmatrix", rsp_rmatrix,       128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(req_ready), 128'(1));
        @(posedge clk); #1;

        // Directed vectors
        vt.push_back(mk(1, 0, F3_W,  32'h100, 32'hDEADBEEF, 0, 0, 1, 1, 32'h0, 0, 0));
        vt.push_back(mk(0, 0, F3_W,  32'h100, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0));
        vt.push_back(mk(0, 0, F3_B,  32'h103, 0, 0, 0, 1, 1, 32'hFFFFFFDE, 0, 0));
        vt.push_back(mk(0, 0, F3_BU, 32'h103, 0, 0, 0, 1, 1, 32'h000000DE, 0, 0));
        vt.push_back(mk(0, 0, F3_H,  32'h102, 0, 0, 0, 1, 1, 32'hFFFFDEAD, 0, 0));
        vt.push_back(mk(1, 0, F3_B,  32'h101, 32'h55, 0, 0, 1, 1, 32'h0, 0, 0));
        vt.push_back(mk(0, 0, F3_W,  32'h100, 0, 0, 0, 1, 1, 32'hDEAD55EF, 0, 0));
        vt.push_back(mk(1, 0, F3_W,  32'h000, 32'h12345678, 0, 0, 1, 1, 32'h0, 0, 0));
        vt.push_back(mk(1, 1, F3_B,  32'h200, 0, MAT, 0, 4, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, F3_B,  32'h200, 0, 0, 0, 4, 0, 0, 1, MAT));
        vt.push_back(mk(0, 0, F3_W,  32'h204, 0, 0, 0, 1, 1, 32'h22222222, 0, 0));
        vt.push_back(mk(0, 0, F3_W,  32'h102, 0, 0, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(0, 1, F3_B,  32'h200, 0, 0, 0, 4, 0, 0, 1, MAT));
        vt.push_back(mk(0, 1, F3_B,  32'h208, 0, 0, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(1, 1, F3_B,  32'h208, 0, ~MAT, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(1, 0, F3_W,  32'h00010000, 32'hBADBAD00, 0, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(0, 0, 3'b011, 32'h100, 0, 0, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(1, 0, 3'b011, 32'h100, 32'hFFFFFFFF, 0, 1, 1, 1, 32'h0, 1, 128'h0));
        vt.push_back(mk(0, 0, F3_W,  32'h000, 0, 0, 0, 1, 1, 32'h12345678, 0, 0));
        vt.push_back(mk(0, 0, F3_W,  32'h100, 0, 0, 0, 1, 1, 32'hDEAD55EF, 0, 0));
        vt.push_back(mk(0, 0, F3_W,  32'h208, 0, 0, 0, 1, 1, 32'h33333333, 0, 0));
        vt.push_back(mk(0, 0, F3_HU, 32'h20E, 0, 0, 0, 1, 1, 32'h00004444, 0, 0));

        foreach (vt[i]) begin
            issue(vt[i].wr, vt[i].wide, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].wmat,
                  lat, e, rd, rm);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vt[i].lat));
            chk($sformatf("vec%0d_err", i), 128'(e), 128'(vt[i].e));
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vt[i].rd));
            if (vt[i].chk_rm) chk($sformatf("vec%0d_rmatrix", i), rm, vt[i].rm);
        end

        // Random traffic confined to 0x300..0x3FF, initialised first
        for (int k = 0; k < 64; k++) begin
            logic [31:0] d;
            d = $urandom;
            model_exec(1, 0, F3_W, 32'h300 + 32'(4*k), d, 0, ee, elat, erd, erm);
            issue(1, 0, F3_W, 32'h300 + 32'(4*k), d, 0, lat, e, rd, rm);
            chk($sformatf("init%0d_lat", k), 128'(lat), 128'(elat));
            chk($sformatf("init%0d_err", k), 128'(e), 128'(ee));
        end
        for (int n = 0; n < 300; n++) begin
            logic wr, wide;
            logic [2:0] f3;
            logic [31:0] addr, wd;
            logic [127:0] wm;
            wide = ($urandom_range(0, 99) < 25);
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            wm   = {$urandom, $urandom, $urandom, $urandom};
            if (wide) begin
                f3   = 3'($urandom_range(0, 7));
                addr = 32'h300 + 32'(16 * $urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) addr = addr + 32'(4 * $urandom_range(1, 3));
            end else begin
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
                else if (wr) f3 = 3'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = F3_B;
                        1: f3 = F3_H;
                        2: f3 = F3_W;
                        3: f3 = F3_BU;
                        default: f3 = F3_HU;
                    endcase
                end
                addr = 32'h300 + 32'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 19) == 0) addr = addr | (32'd1 << $urandom_range(14, 31));
            model_exec(wr, wide, f3, addr, wd, wm, ee, elat, erd, erm);
            issue(wr, wide, f3, addr, wd, wm, lat, e, rd, rm);
            chk($sformatf("rand%0d_lat", n), 128'(lat), 128'(elat));
            chk($sformatf("rand%0d_err", n), 128'(e), 128'(ee));
            if (!wide || ee) chk($sformatf("rand%0d_rdata", n), 128'(rd), 128'(erd));
            if ((wide && !wr) || ee) chk($sformatf("rand%0d_rmatrix", n), rm, erm);
        end

        // Eight back-to-back word loads: one response per cycle
        for (int k = 0; k < 8; k++)
            model_exec(0, 0, F3_W, 32'h300 + 32'(4*k), 0, 0, ee, elat, exp_b2b[k], erm);
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_func3 = F3_W;
                req_addr = 32'h300 + 32'(4*i);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) chk($sformatf("b2b%0d_ready", i), 128'(req_ready), 128'(1));
            if (i >= 1) begin
                chk($sformatf("b2b%0d_valid", i - 1), 128'(rsp_valid), 128'(1));
                chk($sformatf("b2b%0d_rdata", i - 1), 128'(rsp_rdata), 128'(exp_b2b[i-1]));
            end
            @(posedge clk); #1;
        end

        // Request held across a wide burst is accepted only in T+5
        req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 32'h200;
        @(negedge clk);
        chk("hold_ready_T", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_wide = 1'b0; req_func3 = F3_W; req_addr = 32'h204;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_ready_T%0d", c), 128'(req_ready), 128'(c == 5));
            chk($sformatf("hold_valid_T%0d", c), 128'(rsp_valid), 128'(c == 4));
            if (c == 4) chk("hold_rmatrix", rsp_rmatrix, MAT);
            if (c < 5) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("hold_lw_valid", 128'(rsp_valid), 128'(1));
        chk("hold_lw_rdata", 128'(rsp_rdata), 128'(32'h22222222));
        chk("hold_lw_err",   128'(rsp_err),   128'(0));
        @(posedge clk); #1;

        // Reset in T+2 of a wide load abandons it
        req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 32'h200;
        @(negedge clk);
        chk("rstb_ready_T", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstb_ready_in_rst", 128'(req_ready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            if (c == 0) chk("rstb_ready_after", 128'(req_ready), 128'(1));
            @(posedge clk); #1;
        end
        chk("rstb_no_rsp", 128'(seen), 128'(0));
        issue(0, 0, F3_W, 32'h204, 0, 0, lat, e, rd, rm);
        chk("rstb_lw_lat",   128'(lat), 128'(1));
        chk("rstb_lw_rdata", 128'(rd),  128'(32'h22222222));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the pipeline's MEM-stage access port.
- Accepts scalar RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW), plus 128-bit matrix loads and stores.
- Backing store is a byte-enabled, single-port, 32-bit synchronous RAM.
- A 128-bit access is serialised as a 4-beat burst behind a valid/ready request handshake and a single-cycle response pulse.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the backing RAM.
- AW, $clog2(DEPTH_WORDS), word-address width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; transfer occurs when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_wide  in  1  1 = 128-bit matrix access (req_func3 ignored).
- req_func3  in  3  RV32I load/store width code.
- req_addr  in  32  byte address.
- req_wdata  in  32  scalar store data; byte/half use the low bits.
- req_wmatrix  in  128  matrix store data; element k in bits [32k+31:32k].
- rsp_valid  out  1  one-cycle response pulse, for both loads and stores.
- rsp_rdata  out  32  scalar load result, sign/zero extended.
- rsp_rmatrix  out  128  matrix load result.
- rsp_err  out  1  request rejected (misaligned, out of range, or illegal func3).

Behaviour:
- Reset:
  - While rst is high: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_rmatrix=0; state forced to IDLE, beat counter 0.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the burst with no response. Wide-store beats already written remain in RAM.
- States: IDLE, BURST, DONE. req_ready=1 only in IDLE with rst low.
- Scalar access, accepted in cycle T:
  - Store: bytes written at the edge ending T, byte enables from func3 and addr[1:0].
  - Load: RAM read at the same edge.
  - rsp_valid=1 in cycle T+1. State stays IDLE, so back-to-back scalar requests sustain 1 per cycle.
  - Load data: byte/half selected by addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Store response: rsp_rdata=0.
- Wide access, accepted in cycle T:
  - req_wmatrix and the word address are registered at acceptance; the requester may change its inputs from T+1.
  - Beat 0 is issued at the edge ending T; beats 1..3 in BURST during T+1..T+3.
  - Beat k addresses word (addr>>2)+k and writes, or reads into, rsp_rmatrix[32k+31:32k].
  - DONE in T+4: rsp_valid=1, req_ready=0. IDLE again in T+5.
  - Total response latency is 4 cycles; throughput is 1 wide access per 5 cycles.
- Error conditions, each giving rsp_valid=1 and rsp_err=1 in T+1, no RAM write, no burst, rsp_rdata=0 and rsp_rmatrix=0:
  - Halfword with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - Wide with addr[3:0]≠0.
  - addr[31:AW+2]≠0.
  - Illegal func3: load 011/110/111, store ≥011.
- rsp_err is 0 on every non-error response.
- Aligned wide bursts never cross the end of RAM, so no wrap-around handling is needed.
- Output holding: rsp_rdata and rsp_rmatrix hold their last values between responses and are meaningful only while rsp_valid=1.
- Simultaneity: a request presented in a DONE cycle is not accepted (req_ready=0) and must be held by the requester.
- rsp_rmatrix is not updated by scalar loads.

Decomposition:
- Shared package (dmem_pkg):
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State enum: IDLE/BURST/DONE.
  - WIDE_BEATS=4.
  - Byte-enable/extension helper functions.
- Sub-module dmem_bank: DEPTH_WORDS×32 single-port synchronous RAM with 4-bit byte enable and 1-cycle read latency.
- Handshake, FSM, alignment checks and data formatting stay in dmem_responder.

Test Plan:
- Scalar round trip:
  - SW 0xDEADBEEF @0x100, then LW @0x100 → rsp_valid at T+1, rdata=0xDEADBEEF.
  - LB @0x103 → 0xFFFFFFDE; LBU @0x103 → 0x000000DE; LH @0x102 → 0xFFFFDEAD.
- Partial stores: SB 0x55 @0x101 after the SW above, then LW @0x100 → 0xDEAD55EF.
- Wide round trip:
  - Wide store {0x44..,0x33..,0x22..,0x11..} @0x200 → req_ready low for 4 cycles, rsp_valid at T+4.
  - Wide load @0x200 → identical 128 bits; LW @0x204 → 0x22222222.
- Errors, each → rsp_err=1 at T+1 and RAM unchanged:
  - LW @0x102.
  - Wide @0x208.
  - SW @0x00010000 with AW=12.
  - Load func3=011.
- Throughput/backpressure:
  - 8 back-to-back scalar LWs → 8 consecutive rsp_valid pulses.
  - Request held across a wide burst → accepted only in T+5.
- Reset mid-burst: assert rst in cycle T+2 of a wide load → no rsp_valid; req_ready=1 one cycle after rst falls; a subsequent LW returns correct data.
